// File: rtl/aes_arbiter_if.sv
// Requester/core bus of the aes_128 round-robin arbiter.
// The master side is the requester buffers plus the core; the slave side is the arbiter.
interface aes_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [128*NREQ-1:0] req_state;
    logic [128*NREQ-1:0] req_key;
    logic                pause;
    logic [127:0]        core_state;
    logic [127:0]        core_key;
    logic [127:0]        core_out;
    logic [NREQ-1:0]     rsp_valid;
    logic [127:0]        rsp_data;
    logic                busy;

    modport master (
        output req_valid, req_state, req_key, pause, core_out,
        input  req_ready, core_state, core_key, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_state, req_key, pause, core_out,
        output req_ready, core_state, core_key, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/aes_arbiter.sv
// Round-robin arbiter sharing one pipelined aes_128 core among NREQ requesters,
// with a tag pipeline that routes each core result back to its issuer.
module aes_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 21
) (
    input  logic          clk,
    input  logic          rst,
    aes_arbiter_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr_reg;
    logic [PW-1:0]   ptr_next;
    logic [PW-1:0]   grant_idx;
    logic            grant_found;
    logic [NREQ-1:0] grant_onehot;
    logic            fire;

    logic [127:0]    core_state_reg;
    logic [127:0]    core_key_reg;
    logic [127:0]    rsp_data_reg;
    logic [NREQ-1:0] rsp_valid_reg;
    logic [NREQ-1:0] rsp_onehot;

    // Stage LAT lines up with core_out carrying the result of the tagged issue.
    logic [LAT:0]    tag_valid_reg;
    logic [PW-1:0]   tag_id_reg [0:LAT];

    always_comb begin
        int            idx;
        logic [PW-1:0] idx_b;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        idx_b       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx   = (int'(ptr_reg) + k) % NREQ;
            idx_b = PW'(idx);
            if (!grant_found && bus.req_valid[idx_b]) begin
                grant_found = 1'b1;
                grant_idx   = idx_b;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign grant_onehot[gi] = grant_found && !bus.pause && (grant_idx == PW'(gi));
            assign rsp_onehot[gi]   = (tag_id_reg[LAT] == PW'(gi));
        end
    endgenerate

    assign fire     = |grant_onehot;
    assign ptr_next = !fire ? ptr_reg :
                      (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg        <= '0;
            core_state_reg <= '0;
            core_key_reg   <= '0;
            tag_valid_reg  <= '0;
            rsp_valid_reg  <= '0;
            rsp_data_reg   <= '0;
        end else begin
            ptr_reg <= ptr_next;
            if (fire) begin
                core_state_reg <= bus.req_state[128*grant_idx +: 128];
                core_key_reg   <= bus.req_key[128*grant_idx +: 128];
            end
            tag_valid_reg <= {tag_valid_reg[LAT-1:0], fire};
            rsp_valid_reg <= tag_valid_reg[LAT] ? rsp_onehot : '0;
            if (tag_valid_reg[LAT]) begin
                rsp_data_reg <= bus.core_out;
            end
        end
    end

    // Ids are only meaningful alongside their valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        tag_id_reg[0] <= grant_idx;
        for (int k = 1; k <= LAT; k++) begin
            tag_id_reg[k] <= tag_id_reg[k-1];
        end
    end

    assign bus.req_ready  = grant_onehot;
    assign bus.core_state = core_state_reg;
    assign bus.core_key   = core_key_reg;
    assign bus.rsp_valid  = rsp_valid_reg;
    assign bus.rsp_data   = rsp_data_reg;
    assign bus.busy       = (|tag_valid_reg) || (|rsp_valid_reg);
endmodule

// File: tb/tb_aes_arbiter.sv
// Bench for aes_arbiter: a stand-in LAT-cycle core, a round-robin reference
// model, and a scoreboard of expected responses checked as they emerge.
module tb_aes_arbiter;
    localparam int NREQ = 4;
    localparam int LAT  = 21;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_arbiter_if #(.NREQ(NREQ)) bus ();

    aes_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]   onehot;
        logic [127:0] data;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    int           mptr  = 0;
    int           g;
    logic [127:0] st [0:3];
    logic [127:0] ky [0:3];
    logic [127:0] core_pipe [0:LAT-1];

    function automatic logic [127:0] fcore(input logic [127:0] s, input logic [127:0] k);
        return s ^ {k[94:0], k[127:95]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Stand-in core: result of the registered inputs appears LAT edges later.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        core_pipe[0] <= fcore(bus.core_state, bus.core_key);
        for (int k = 1; k < LAT; k++) core_pipe[k] <= core_pipe[k-1];
    end
    assign bus.core_out = core_pipe[LAT-1];

    always @(negedge clk) begin
        if (bus.rsp_valid !== 4'b0000) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected cyc=%0d got_valid=%b got_data=%h exp=none",
                         cyc, bus.rsp_valid, bus.rsp_data);
            end else begin
                mon_e = sb.pop_front();
                if (bus.rsp_valid !== mon_e.onehot || bus.rsp_data !== mon_e.data || cyc != mon_e.cyc) begin
                    bad++;
                    $display("FAIL rsp cyc=%0d got_valid=%b got_data=%h exp_cyc=%0d exp_valid=%b exp_data=%h",
                             cyc, bus.rsp_valid, bus.rsp_data, mon_e.cyc, mon_e.onehot, mon_e.data);
                end else begin
                    $display("rsp cyc=%0d valid=%b data=%h", cyc, bus.rsp_valid, bus.rsp_data);
                end
            end
        end
    end

    // One cycle: drive inputs at negedge, check req_ready, score the grant, move to next negedge.
    task automatic drive(input logic [3:0] v, input logic p, output int gi);
        logic [3:0] expr;
        exp_t       e;
        bus.req_valid = v;
        bus.pause     = p;
        for (int k = 0; k < NREQ; k++) begin
            bus.req_state[128*k +: 128] = st[k];
            bus.req_key[128*k +: 128]   = ky[k];
        end
        #1;
        gi   = -1;
        expr = 4'b0000;
        if (!p) begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (mptr + k) % NREQ;
                if (gi < 0 && v[j]) gi = j;
            end
        end
        if (gi >= 0) expr[gi] = 1'b1;
        total++;
        if (bus.req_ready !== expr) begin
            bad++;
            $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, expr);
        end
        if (gi >= 0) begin
            e.onehot = expr;
            e.data   = fcore(st[gi], ky[gi]);
            e.cyc    = cyc + LAT + 2;
            sb.push_back(e);
            mptr = (gi + 1) % NREQ;
            $display("grant cyc=%0d req=%0d", cyc, gi);
        end
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int d;
        for (int n = 0; n < 200 && (sb.size() != 0 || bus.busy !== 1'b0); n++) drive(4'b0000, 1'b0, d);
        total++;
        if (sb.size() != 0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL drain cyc=%0d got_pending=%0d got_busy=%b exp_pending=0 exp_busy=0",
                     cyc, sb.size(), bus.busy);
        end
    endtask

    task automatic pulse_reset();
        #1;
        rst = 1'b1;
        bus.req_valid = 4'b0000;
        sb.delete();
        mptr = 0;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 4'b0000) begin
            bad++;
            $display("FAIL reset_clear cyc=%0d got_busy=%b got_rsp=%b exp=0", cyc, bus.busy, bus.rsp_valid);
        end
    endtask

    task automatic test_reset();
        total++;
        if (bus.core_state !== 128'h0 || bus.core_key !== 128'h0 || bus.rsp_data !== 128'h0 ||
            bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b0 || bus.req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL reset_state got st=%h key=%h data=%h valid=%b busy=%b ready=%b exp=all zero",
                     bus.core_state, bus.core_key, bus.rsp_data, bus.rsp_valid, bus.busy, bus.req_ready);
        end
        rst = 1'b0;
        $display("reset checked cyc=%0d", cyc);
    endtask

    task automatic test_single();
        st[2] = 128'h00112233445566778899aabbccddeeff;
        ky[2] = 128'h000102030405060708090a0b0c0d0e0f;
        drive(4'b0100, 1'b0, g);
        total++;
        if (bus.core_state !== 128'h00112233445566778899aabbccddeeff ||
            bus.core_key !== 128'h000102030405060708090a0b0c0d0e0f) begin
            bad++;
            $display("FAIL core_load got st=%h key=%h exp st=%h key=%h", bus.core_state, bus.core_key,
                     128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f);
        end
        wait_drain();
    endtask

    task automatic test_all_four();
        logic [3:0] v;
        pulse_reset();
        v = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            drive(v, 1'b0, g);
            total++;
            if (g != i) begin
                bad++;
                $display("FAIL all_four_order got=%0d exp=%0d", g, i);
            end
            if (g >= 0) begin
                v[g]  = 1'b0;
                st[g] = rnd128();
            end
        end
        wait_drain();
    endtask

    task automatic test_fairness();
        for (int n = 0; n < 8; n++) begin
            drive(4'b1010, 1'b0, g);
            total++;
            if (g != ((n % 2 == 0) ? 1 : 3)) begin
                bad++;
                $display("FAIL fairness n=%0d got=%0d exp=%0d", n, g, (n % 2 == 0) ? 1 : 3);
            end
            if (g >= 0) st[g] = rnd128();
        end
        wait_drain();
    endtask

    task automatic test_sustained();
        logic [127:0] base;
        base = rnd128();
        ky[0] = rnd128();
        for (int n = 0; n < 50; n++) begin
            st[0] = base + 128'(n);
            drive(4'b0001, 1'b0, g);
            total++;
            if (g != 0) begin
                bad++;
                $display("FAIL sustained n=%0d got=%0d exp=0", n, g);
            end
        end
        wait_drain();
    endtask

    task automatic test_pause();
        drive(4'b1111, 1'b0, g);
        drive(4'b1111, 1'b0, g);
        for (int n = 0; n < 19; n++) drive(4'b0000, 1'b0, g);
        for (int n = 0; n < 5; n++) drive(4'b1111, 1'b1, g);
        drive(4'b1111, 1'b0, g);
        total++;
        if (g != 3) begin
            bad++;
            $display("FAIL pause_resume got=%0d exp=3", g);
        end
        wait_drain();
    endtask

    task automatic test_reset_midflight();
        for (int n = 0; n < 3; n++) drive(4'b1111, 1'b0, g);
        for (int n = 0; n < 10; n++) drive(4'b0000, 1'b0, g);
        pulse_reset();
        for (int n = 0; n < 30; n++) drive(4'b0000, 1'b0, g);
        drive(4'b1111, 1'b0, g);
        total++;
        if (g != 0) begin
            bad++;
            $display("FAIL reset_first_grant got=%0d exp=0", g);
        end
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.req_valid = 4'b0000;
        bus.pause     = 1'b0;
        bus.req_state = '0;
        bus.req_key   = '0;
        for (int k = 0; k < NREQ; k++) begin
            st[k] = rnd128();
            ky[k] = rnd128();
        end
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_sustained();
        test_pause();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
